// File: rtl/axil_regfile.sv
// AXI4-Lite register file: SREG_COUNT read-only status registers followed by
// CREG_COUNT control registers. Define AXIL_REGFILE_WSTRB_EN to honour WSTRB byte lanes.
//
// state  | meaning
// W_IDLE | collecting AW and W independently; write fires once both are held
// W_RESP | BVALID asserted, waiting for BREADY
// R_IDLE | ARREADY asserted, waiting for an address
// R_RESP | RVALID asserted with latched data, waiting for RREADY
module axil_regfile #(
    parameter int SREG_COUNT = 6,
    parameter int CREG_COUNT = 10,
    parameter int ADDR_BITS  = 7,
    parameter logic [CREG_COUNT*32-1:0] CREG_DEFAULTS = '0,
    parameter logic [CREG_COUNT-1:0]    CREG_SELFCLR  = '0
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [31:0]                      S_AXI_AWADDR,
    input  logic [2:0]                       S_AXI_AWPROT,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [31:0]                      S_AXI_WDATA,
    input  logic [3:0]                       S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [31:0]                      S_AXI_ARADDR,
    input  logic [2:0]                       S_AXI_ARPROT,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [31:0]                      S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    input  logic [SREG_COUNT*32-1:0]         i_sreg,
    output logic [CREG_COUNT*32-1:0]         o_creg,
    output logic [CREG_COUNT-1:0]            o_creg_wstrobe,
    output logic [SREG_COUNT+CREG_COUNT-1:0] o_reg_rstrobe
);

    localparam int NREG  = SREG_COUNT + CREG_COUNT;
    localparam int IDX_W = ADDR_BITS - 2;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t          wstate, wstate_nxt;
    rstate_t          rstate, rstate_nxt;
    logic             active;
    logic             aw_held, w_held;
    logic             aw_hs, w_hs, wr_fire, ar_fire;
    logic [IDX_W-1:0] aw_idx_q, wr_idx, ar_idx;
    logic [31:0]      w_data_q, wr_data;
    logic [3:0]       w_strb_q, wr_strb;
    logic [31:0]      rd_val;
    logic             rd_hit;
    logic [NREG-1:0]  rd_sel;
    logic             unused_ok;

    // Handshakes are blocked until the first edge after reset releases.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active <= 1'b0;
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            active <= 1'b1;
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
        end
    end

    always_comb begin
        wstate_nxt    = wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        wr_fire       = 1'b0;
        case (wstate)
            W_IDLE: begin
                S_AXI_AWREADY = active && !aw_held;
                S_AXI_WREADY  = active && !w_held;
                aw_hs         = S_AXI_AWVALID && active && !aw_held;
                w_hs          = S_AXI_WVALID && active && !w_held;
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    wr_fire    = 1'b1;
                    wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_nxt    = rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        ar_fire       = 1'b0;
        case (rstate)
            R_IDLE: begin
                S_AXI_ARREADY = active;
                ar_fire       = S_AXI_ARVALID && active;
                if (ar_fire) rstate_nxt = R_RESP;
            end
            R_RESP: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_BITS-1:2];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
        end
    end

    // Same-cycle completion bypasses the holding registers.
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_BITS-1:2];
    assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            S_AXI_BRESP <= 2'b00;
        end else if (wr_fire) begin
            if ({1'b0, wr_idx} < (IDX_W+1)'(SREG_COUNT))
                S_AXI_BRESP <= 2'b10;
            else if ({1'b0, wr_idx} >= (IDX_W+1)'(NREG))
                S_AXI_BRESP <= 2'b11;
            else
                S_AXI_BRESP <= 2'b00;
        end
    end

    for (genvar k = 0; k < CREG_COUNT; k++) begin : g_creg
        localparam logic [31:0] DEF = CREG_DEFAULTS[k*32 +: 32];
        logic [31:0] val;
        logic [31:0] wr_merged;
        logic        stb;
        logic        hit;

        assign hit = wr_fire && ({1'b0, wr_idx} == (IDX_W+1)'(SREG_COUNT + k));

`ifdef AXIL_REGFILE_WSTRB_EN
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign wr_merged[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : val[8*b +: 8];
        end
`else
        assign wr_merged = wr_data;
`endif

        // Self-clearing registers revert on every edge they are not written.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                val <= DEF;
                stb <= 1'b0;
            end else begin
                stb <= hit;
                if (hit)
                    val <= wr_merged;
                else if (CREG_SELFCLR[k])
                    val <= DEF;
            end
        end

        assign o_creg[k*32 +: 32] = val;
        assign o_creg_wstrobe[k]  = stb;
    end

    assign ar_idx = S_AXI_ARADDR[ADDR_BITS-1:2];

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b0;
        rd_sel = '0;
        for (int k = 0; k < SREG_COUNT; k++) begin
            if ({1'b0, ar_idx} == (IDX_W+1)'(k)) begin
                rd_val    = i_sreg[k*32 +: 32];
                rd_hit    = 1'b1;
                rd_sel[k] = 1'b1;
            end
        end
        for (int k = 0; k < CREG_COUNT; k++) begin
            if ({1'b0, ar_idx} == (IDX_W+1)'(SREG_COUNT + k)) begin
                rd_val                 = o_creg[k*32 +: 32];
                rd_hit                 = 1'b1;
                rd_sel[SREG_COUNT + k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            o_reg_rstrobe <= '0;
        end else begin
            o_reg_rstrobe <= '0;
            if (ar_fire) begin
                S_AXI_RDATA   <= rd_val;
                S_AXI_RRESP   <= rd_hit ? 2'b00 : 2'b11;
                o_reg_rstrobe <= rd_sel;
            end
        end
    end

`ifdef AXIL_REGFILE_WSTRB_EN
    assign unused_ok = ^{S_AXI_AWADDR[31:ADDR_BITS], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:ADDR_BITS], S_AXI_ARADDR[1:0],
                         S_AXI_AWPROT, S_AXI_ARPROT};
`else
    assign unused_ok = ^{S_AXI_AWADDR[31:ADDR_BITS], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:ADDR_BITS], S_AXI_ARADDR[1:0],
                         S_AXI_AWPROT, S_AXI_ARPROT, wr_strb};
`endif

endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile; expectations follow
// AXIL_REGFILE_WSTRB_EN when the macro is defined for the build.
module tb_axil_regfile;

    localparam int SREG_COUNT = 6;
    localparam int CREG_COUNT = 10;
    localparam int ADDR_BITS  = 7;
    localparam int NREG       = SREG_COUNT + CREG_COUNT;
    localparam logic [CREG_COUNT*32-1:0] DEFAULTS = {
        32'h0000_0055, 32'h0, 32'h0, 32'h0000_07D0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_07D0};
    localparam logic [CREG_COUNT-1:0] SELFCLR = 10'b10_0000_0000;
    localparam logic [SREG_COUNT*32-1:0] SREG_VAL = {
        32'hA000_0005, 32'hA000_0004, 32'hA000_0003,
        32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [CREG_COUNT*32-1:0] o_creg;
    logic [CREG_COUNT-1:0]    o_creg_wstrobe;
    logic [NREG-1:0]          o_reg_rstrobe;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axil_regfile #(
        .SREG_COUNT(SREG_COUNT), .CREG_COUNT(CREG_COUNT), .ADDR_BITS(ADDR_BITS),
        .CREG_DEFAULTS(DEFAULTS), .CREG_SELFCLR(SELFCLR)
    ) dut (
        .clk(clk), .resetn(resetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .i_sreg(SREG_VAL), .o_creg(o_creg), .o_creg_wstrobe(o_creg_wstrobe), .o_reg_rstrobe(o_reg_rstrobe)
    );

    // Returns at the negedge one cycle after BVALID was first seen.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [CREG_COUNT-1:0] wstb,
                             output logic [CREG_COUNT*32-1:0] creg_after);
        int  n;
        bit  aw_ok, w_ok;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_ok = 1'b0; w_ok = 1'b0; n = 0;
        while (!(aw_ok && w_ok) && n < 50) begin
            if (awvalid && awready) aw_ok = 1'b1;
            if (wvalid && wready) w_ok = 1'b1;
            @(negedge clk);
            if (aw_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!bvalid) begin
            miscompares++;
            $display("FAIL write_timeout addr %h: bvalid got %b expected 1", addr, bvalid);
        end
        resp = bresp; wstb = o_creg_wstrobe; creg_after = o_creg;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output logic [NREG-1:0] rstb);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1; n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!rvalid) begin
            miscompares++;
            $display("FAIL read_timeout addr %h: rvalid got %b expected 1", addr, rvalid);
        end
        data = rdata; resp = rresp; rstb = o_reg_rstrobe;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; logic [NREG-1:0] rs;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: got %b expected 00000", {awready, wready, arready, bvalid, rvalid});
        end
        vectors++;
        if ({o_creg_wstrobe, o_reg_rstrobe, bresp, rresp, rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_zero_outputs: wstb %h rstb %h bresp %h rresp %h rdata %h expected all 0",
                     o_creg_wstrobe, o_reg_rstrobe, bresp, rresp, rdata);
        end
        vectors++;
        if (o_creg !== DEFAULTS) begin
            miscompares++;
            $display("FAIL reset_creg: got %h expected %h", o_creg, DEFAULTS);
        end
        resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({awready, wready, arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ready_rise: got %b expected 111", {awready, wready, arready});
        end
        vectors++;
        if (o_creg[31:0] !== 32'd2000) begin
            miscompares++;
            $display("FAIL reset_creg0: got %h expected %h", o_creg[31:0], 32'd2000);
        end
        axi_read(32'h30, d, r, rs);
        vectors++;
        if (d !== 32'h7D0 || r !== 2'b00 || rs !== 16'h1000) begin
            miscompares++;
            $display("FAIL reset_read_idx12: data %h resp %h rstb %h expected 000007d0 0 1000", d, r, rs);
        end
    endtask

    task automatic test_w_before_aw();
        @(negedge clk);
        bready = 1'b0; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (o_creg[31:0] !== 32'h7D0 || o_creg_wstrobe !== '0 || bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL w_alone_no_write: creg0 %h wstb %h bvalid %b expected 000007d0 000 0",
                     o_creg[31:0], o_creg_wstrobe, bvalid);
        end
        awaddr = 32'h18; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        vectors++;
        if (o_creg[31:0] !== 32'hDEADBEEF || o_creg_wstrobe !== 10'b1 || bvalid !== 1'b1 || bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL w_before_aw_write: creg0 %h wstb %h bvalid %b bresp %h expected deadbeef 001 1 0",
                     o_creg[31:0], o_creg_wstrobe, bvalid, bresp);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bvalid !== 1'b1 || o_creg_wstrobe !== '0 || awready !== 1'b0) begin
                miscompares++;
                $display("FAIL bvalid_hold cycle %0d: bvalid %b wstb %h awready %b expected 1 000 0",
                         i, bvalid, o_creg_wstrobe, awready);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL bvalid_release: got %b expected 0", bvalid);
        end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [CREG_COUNT-1:0] ws; logic [CREG_COUNT*32-1:0] c;
        logic [31:0] d; logic [NREG-1:0] rs; logic [CREG_COUNT*32-1:0] model;
        model = DEFAULTS;
        model[31:0] = 32'hDEADBEEF;
        axi_write(32'h04, 32'h12345678, 4'hF, r, ws, c);
        vectors++;
        if (r !== 2'b10 || ws !== '0 || c !== model) begin
            miscompares++;
            $display("FAIL status_write_slverr: resp %h wstb %h creg %h expected 2 000 %h", r, ws, c, model);
        end
        axi_read(32'h04, d, r, rs);
        vectors++;
        if (d !== 32'hA000_0001 || r !== 2'b00 || rs !== 16'h0002) begin
            miscompares++;
            $display("FAIL status_read: data %h resp %h rstb %h expected a0000001 0 0002", d, r, rs);
        end
        axi_write(32'h40, 32'h12345678, 4'hF, r, ws, c);
        vectors++;
        if (r !== 2'b11 || ws !== '0 || c !== model) begin
            miscompares++;
            $display("FAIL oob_write_decerr: resp %h wstb %h creg %h expected 3 000 %h", r, ws, c, model);
        end
        axi_read(32'h40, d, r, rs);
        vectors++;
        if (d !== 32'h0 || r !== 2'b11 || rs !== '0) begin
            miscompares++;
            $display("FAIL oob_read_decerr: data %h resp %h rstb %h expected 0 3 0", d, r, rs);
        end
        axi_read(32'h3C, d, r, rs);
        vectors++;
        if (d !== 32'h55 || r !== 2'b00 || rs !== 16'h8000) begin
            miscompares++;
            $display("FAIL last_reg_read: data %h resp %h rstb %h expected 00000055 0 8000", d, r, rs);
        end
        axi_write(32'hFFFF_FF9B, 32'hCAFE0001, 4'hF, r, ws, c);
        model[31:0] = 32'hCAFE0001;
        vectors++;
        if (r !== 2'b00 || ws !== 10'b1 || c !== model) begin
            miscompares++;
            $display("FAIL addr_alias_write: resp %h wstb %h creg %h expected 0 001 %h", r, ws, c, model);
        end
        axi_write(32'h18, 32'hCAFE0001, 4'hF, r, ws, c);
        vectors++;
        if (r !== 2'b00 || ws !== 10'b1 || c[31:0] !== 32'hCAFE0001) begin
            miscompares++;
            $display("FAIL same_value_strobe: resp %h wstb %h creg0 %h expected 0 001 cafe0001", r, ws, c[31:0]);
        end
    endtask

    task automatic test_selfclr();
        logic [1:0] r; logic [CREG_COUNT-1:0] ws; logic [CREG_COUNT*32-1:0] c;
        axi_write(32'h3C, 32'h1, 4'hF, r, ws, c);
        vectors++;
        if (r !== 2'b00 || ws !== 10'b10_0000_0000 || c[9*32 +: 32] !== 32'h1) begin
            miscompares++;
            $display("FAIL selfclr_pulse: resp %h wstb %h creg9 %h expected 0 200 00000001", r, ws, c[9*32 +: 32]);
        end
        vectors++;
        if (o_creg[9*32 +: 32] !== 32'h55) begin
            miscompares++;
            $display("FAIL selfclr_revert: got %h expected 00000055", o_creg[9*32 +: 32]);
        end
        @(negedge clk);
        vectors++;
        if (o_creg[9*32 +: 32] !== 32'h55) begin
            miscompares++;
            $display("FAIL selfclr_stays: got %h expected 00000055", o_creg[9*32 +: 32]);
        end
    endtask

    task automatic test_wstrb();
        logic [1:0] r; logic [CREG_COUNT-1:0] ws; logic [CREG_COUNT*32-1:0] c;
        logic [31:0] exp1, exp2, d; logic [NREG-1:0] rs;
`ifdef AXIL_REGFILE_WSTRB_EN
        exp1 = 32'h11BB33DD;
        exp2 = 32'h11BB33DD;
`else
        exp1 = 32'hAABBCCDD;
        exp2 = 32'h00000000;
`endif
        axi_write(32'h1C, 32'h11223344, 4'hF, r, ws, c);
        axi_write(32'h1C, 32'hAABBCCDD, 4'b0101, r, ws, c);
        vectors++;
        if (r !== 2'b00 || ws !== 10'b10 || c[63:32] !== exp1) begin
            miscompares++;
            $display("FAIL wstrb_0101: resp %h wstb %h creg1 %h expected 0 002 %h", r, ws, c[63:32], exp1);
        end
        axi_write(32'h1C, 32'h00000000, 4'b0000, r, ws, c);
        vectors++;
        if (r !== 2'b00 || ws !== 10'b10 || c[63:32] !== exp2) begin
            miscompares++;
            $display("FAIL wstrb_0000: resp %h wstb %h creg1 %h expected 0 002 %h", r, ws, c[63:32], exp2);
        end
        axi_read(32'h1C, d, r, rs);
        vectors++;
        if (d !== exp2 || r !== 2'b00 || rs !== 16'h0080) begin
            miscompares++;
            $display("FAIL wstrb_readback: data %h resp %h rstb %h expected %h 0 0080", d, r, rs, exp2);
        end
    endtask

    task automatic test_concurrent_same_reg();
        logic [1:0] r; logic [CREG_COUNT-1:0] ws; logic [CREG_COUNT*32-1:0] c;
        axi_write(32'h20, 32'h11111111, 4'hF, r, ws, c);
        @(negedge clk);
        awaddr = 32'h20; wdata = 32'h22222222; wstrb = 4'hF; araddr = 32'h20;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'h11111111 || o_creg[95:64] !== 32'h22222222 || bvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_rw: rvalid %b rdata %h creg2 %h bvalid %b expected 1 11111111 22222222 1",
                     rvalid, rdata, o_creg[95:64], bvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int nw, nr;
        nw = 0; nr = 0;
        @(negedge clk);
        awaddr = 32'h24; wdata = 32'h33330000; wstrb = 4'hF; araddr = 32'h24;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_creg_wstrobe[3]) nw++;
            if (o_reg_rstrobe[9]) nr++;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        vectors++;
        if (nw !== 4 || nr !== 4) begin
            miscompares++;
            $display("FAIL back_to_back_rate: writes %0d reads %0d expected 4 4", nw, nr);
        end
        @(negedge clk);
        vectors++;
        if (o_creg[127:96] !== 32'h33330000 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_end: creg3 %h bvalid %b rvalid %b expected 33330000 0 0",
                     o_creg[127:96], bvalid, rvalid);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        bready = 1'b0;
        awaddr = 32'h20; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        vectors++;
        if (o_creg !== DEFAULTS) begin
            miscompares++;
            $display("FAIL mid_reset_creg: got %h expected %h", o_creg, DEFAULTS);
        end
        @(negedge clk);
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bvalid !== 1'b0 || o_creg_wstrobe !== '0 || o_creg[95:64] !== 32'h0) begin
                miscompares++;
                $display("FAIL mid_reset_no_write cycle %0d: bvalid %b wstb %h creg2 %h expected 0 000 0",
                         i, bvalid, o_creg_wstrobe, o_creg[95:64]);
            end
            @(negedge clk);
        end
        awaddr = 32'h20; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        vectors++;
        if (bvalid !== 1'b1 || o_creg_wstrobe !== 10'b100 || o_creg[95:64] !== 32'h5A5A5A5A) begin
            miscompares++;
            $display("FAIL mid_reset_new_aw: bvalid %b wstb %h creg2 %h expected 1 004 5a5a5a5a",
                     bvalid, o_creg_wstrobe, o_creg[95:64]);
        end
        bready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_w_before_aw();
        test_errors();
        test_selfclr();
        test_wstrb();
        test_concurrent_same_reg();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
